// File: rtl/tetris_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tetris_pkg: shared piece types, spawn constants and helpers              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_type_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rotation_t;

    typedef struct packed {
        piece_type_t ptype;
        rotation_t   rotation;
        logic [3:0]  x;
        logic [4:0]  y;
    } active_piece_t;

    // Bit n set means piece_type_t value n is still in the current bag.
    typedef logic [6:0] bag_mask_t;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [3:0]  SPAWN_X    = 4'd7;
    localparam logic [4:0]  SPAWN_Y    = 5'd0;
    localparam bag_mask_t   c_BAG_FULL = 7'h7F;

    function automatic active_piece_t make_piece(input piece_type_t ptype);
        active_piece_t p;
        p.ptype    = ptype;
        p.rotation = ROT_0;
        p.x        = SPAWN_X;
        p.y        = SPAWN_Y;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tetris_lfsr16: free-running 16-bit Galois LFSR with guarded reload       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tetris_lfsr16
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [15:0] load_val_i,
    output logic [7:0] rnd_o
);

    localparam logic [15:0] c_RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // A zero state would lock the register, so a zero load becomes 1.
    always_comb begin
        state_d = state_q >> 1;
        if (load_i) begin
            state_d = (load_val_i == 16'h0000) ? 16'h0001 : load_val_i;
        end else if (state_q[0]) begin
            state_d = (state_q >> 1) ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign rnd_o = state_q[7:0];

endmodule
`default_nettype wire

// File: rtl/tetris_piece_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tetris_piece_gen: 7-bag spawn-piece generator with preview queue         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tetris_piece_gen
    import tetris_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          PREVIEW_DEPTH = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              piece_ready,
    output logic                              piece_valid,
    output active_piece_t                     piece_out,
    output piece_type_t [PREVIEW_DEPTH-1:0]   preview,
    input  logic                              seed_load,
    input  logic [15:0]                       seed
);

    localparam int QLEN = PREVIEW_DEPTH + 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    piece_type_t [QLEN-1:0]  queue_q;
    bag_mask_t               mask_q;
    bag_mask_t               mask_d;
    logic [2:0]              fill_cnt_q;
    logic                    valid_q;

    logic [7:0]              w_rnd;
    logic [2:0]              w_count;
    logic [2:0]              w_div;
    logic [2:0]              w_k;
    logic [2:0]              w_seen;
    piece_type_t             w_pick;
    bag_mask_t               w_mask_clr;
    logic                    w_draw;

    tetris_lfsr16 #(
        .SEED       (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (seed_load),
        .load_val_i (seed),
        .rnd_o      (w_rnd)
    );

    always_comb begin
        w_count = 3'd0;
        for (int i = 0; i < 7; i++) begin
            w_count = w_count + {2'b00, mask_q[i]};
        end
    end

    // The mask is never empty, so the zero-divisor branch is unreachable.
    assign w_div = (w_count == 3'd0) ? 3'd1 : w_count;
    assign w_k   = 3'(w_rnd % {5'd0, w_div});

    always_comb begin
        w_pick = PIECE_I;
        w_seen = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (mask_q[i]) begin
                if (w_seen == w_k) begin
                    w_pick = piece_type_t'(3'(i));
                end
                w_seen = w_seen + 3'd1;
            end
        end
    end

    assign w_mask_clr = mask_q & ~(7'b000_0001 << w_pick);
    assign mask_d     = (w_mask_clr == 7'h00) ? c_BAG_FULL : w_mask_clr;
    assign w_draw     = (state_q == ST_FILL) || (valid_q && piece_ready);

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            state_q    <= ST_FILL;
            mask_q     <= c_BAG_FULL;
            fill_cnt_q <= 3'd0;
            valid_q    <= 1'b0;
            for (int i = 0; i < QLEN; i++) begin
                queue_q[i] <= PIECE_I;
            end
        end else if (w_draw) begin
            mask_q <= mask_d;
            for (int i = 0; i < QLEN - 1; i++) begin
                queue_q[i] <= queue_q[i+1];
            end
            queue_q[QLEN-1] <= w_pick;
            if (state_q == ST_FILL) begin
                if (fill_cnt_q == 3'(PREVIEW_DEPTH)) begin
                    state_q <= ST_RUN;
                    valid_q <= 1'b1;
                end else begin
                    fill_cnt_q <= fill_cnt_q + 3'd1;
                end
            end
        end
    end

    assign piece_valid = valid_q;
    assign piece_out   = make_piece(queue_q[0]);

    for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
        assign preview[g] = queue_q[g+1];
    end

endmodule
`default_nettype wire

// File: doc/tetris_piece_gen.md
# tetris_piece_gen

Spawn-piece generator for the Tetris game logic, clocked in the GAME clock domain. Produces the stream of new falling pieces as `active_piece_t` spawn values, using a 7-bag randomizer: every aligned group of 7 pieces holds each `piece_type_t` exactly once. It feeds the active-piece controller through a valid/ready handshake and exposes a preview queue for the next-piece display.

## Interface
Parameters:
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset; must be nonzero.
- `PREVIEW_DEPTH`, default 3: number of upcoming pieces exposed; legal range 1..4.

Ports:
- `clk`  in  1  GAME clock.
- `reset`  in  1  synchronous, active-high reset.
- `piece_ready`  in  1  consumer accepts `piece_out` this cycle.
- `piece_valid`  out  1  `piece_out` holds a valid spawn piece.
- `piece_out`  out  `active_piece_t`  next piece to spawn.
- `preview`  out  `PREVIEW_DEPTH` x `piece_type_t`  upcoming types; `preview[0]` is the type after `piece_out`.
- `seed_load`  in  1  reseed and restart the generator.
- `seed`  in  16  new LFSR value, sampled when `seed_load`=1.

## Operation
- 16-bit Galois LFSR with taps 16'hB400 (x^16+x^14+x^13+x^11+1). It shifts every cycle, independent of the handshake.
- Bag: 7-bit mask of types not yet drawn, bit n = `piece_type_t` value n. Let count = popcount(mask), which is 1..7. A draw selects index k = `lfsr[7:0] % count`, then picks the k-th set bit of the mask, counting from bit 0 upward. Every draw takes one cycle.
- After a draw, the selected bit is cleared. If the result is 0, the mask reloads to 7'h7F in the same update, so the bag never stalls.
- Queue: shift register of `PREVIEW_DEPTH`+1 types. Entry 0 drives `piece_out`; entries 1..N drive `preview`.
- FSM:
  - FILL: draws one type per cycle into the tail. Moves to RUN once the queue is full. `piece_valid`=0.
  - RUN: `piece_valid`=1. On `piece_valid & piece_ready`, the queue shifts by one and a new draw is appended at the tail in the same cycle. Without a handshake, the queue and mask hold.
- `piece_out` fields: the queued type, `rotation`=ROT_0, `x`=SPAWN_X (7), `y`=SPAWN_Y (0).
- `seed_load` (when not in reset):
  - LFSR <= `seed`, or 16'h0001 if `seed`==0.
  - mask <= 7'h7F, queue cleared, FSM -> FILL.
  - Takes priority over the handshake. A handshake in the same cycle is dropped, and the consumer sees `piece_valid`=0 from the next cycle.
- Reset state:
  - LFSR = `LFSR_SEED`, mask = 7'h7F, FSM = FILL, `piece_valid`=0.
  - All queue entries = PIECE_I, so `piece_out` = {PIECE_I, ROT_0, x=7, y=0} and `preview` is all PIECE_I.
- Reset overrides `seed_load`.

## Timing
- Fill latency: after `reset` or `seed_load` deasserts, `piece_valid` rises `PREVIEW_DEPTH`+1 cycles later (4 cycles with the default).
- Handshake: `piece_out` and `preview` change only on a handshake, on `seed_load`, or during FILL. In RUN they are stable while `piece_ready`=0.
- Throughput: one piece per cycle when `piece_ready` is held high.
- `piece_valid` never drops in RUN except via `seed_load` or `reset`.
- Outputs are registered. There is no combinational path from `piece_ready` to `piece_valid`.

## Structure
- Add to `tetris_pkg`:
  - `bag_mask_t` (logic [6:0]).
  - `LFSR_TAPS` = 16'hB400.
  - `SPAWN_X` = 4'd7 and `SPAWN_Y` = 5'd0; `make_piece` uses these.
- Sub-module `tetris_lfsr16`: step/load LFSR with zero-seed guard, instantiated once.
- Bag selection (popcount, modulo by a 1..7 divisor, k-th set bit) stays as combinational logic in this module.

## Test plan
- Reset then `piece_ready`=1: `piece_valid`=0 for exactly 4 cycles, then 1. `piece_out` has rotation ROT_0, x=7, y=0.
- Continuous draw of 70 pieces: each aligned group of 7 accepted pieces contains each of the 7 types exactly once. `preview[0]` equals the next accepted `piece_out`.
- Hold `piece_ready`=0 for 20 cycles in RUN: `piece_out`, `preview` and `piece_valid` are unchanged.
- `seed_load` with `seed`=16'h1234 twice, each followed by 21 draws: the two type sequences are identical. `seed_load` in the same cycle as a handshake: `piece_valid`=0 on the next cycle.
- `seed`=16'h0000 loaded: the generator still produces valid bags, and the LFSR never sticks at 0.
- Assert `reset` mid-RUN with `piece_ready`=1: outputs return to the reset values on the next cycle, and the fill latency of 4 cycles repeats.
